// File: rtl/encrypt_sched_pkg.sv
// rtl/encrypt_sched_pkg.sv - key/block widths, FSM encodings and helpers shared by encrypt_sched and its benches
`ifndef ENCRYPT_SCHED_PARAMS
`define ENCRYPT_SCHED_PARAMS
`define N_K 16
`define N_B 16
`define ENCRYPT_SCHED_IDLE 2'd0
`define ENCRYPT_SCHED_WAIT 2'd1
`define ENCRYPT_SCHED_DONE 2'd2
`endif

package encrypt_sched_pkg;

    localparam int N_K = `N_K;
    localparam int N_B = `N_B;

    typedef enum logic [1:0] {
        ST_IDLE = `ENCRYPT_SCHED_IDLE,
        ST_WAIT = `ENCRYPT_SCHED_WAIT,
        ST_DONE = `ENCRYPT_SCHED_DONE
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/encrypt_sched_comb.sv
// rtl/encrypt_sched_comb.sv - encrypt_comb: single-cycle combinational block mixer shared by encrypt_sched
module encrypt_comb
    import encrypt_sched_pkg::*;
(
    input  logic [N_K-1:0] k,
    input  logic [N_B-1:0] m,
    output logic [N_B-1:0] c
);

    logic [N_B-1:0] x;
    logic [N_K-1:0] k_swap;

    // whiten, rotate left by 3, then add the half-swapped key
    assign x      = m ^ N_B'(k);
    assign k_swap = {k[N_K/2-1:0], k[N_K-1:N_K/2]};
    assign c      = {x[N_B-4:0], x[N_B-1:N_B-3]} + N_B'(k_swap);

endmodule

// File: rtl/encrypt_sched.sv
// rtl/encrypt_sched.sv - round-robin scheduler sharing one encrypt_comb; ENCRYPT_SCHED_STATS_EN adds done_cnt
module encrypt_sched
    import encrypt_sched_pkg::*;
#(
    parameter  int N_REQ  = 2,
    parameter  int SETTLE = 2,
    parameter  int CNT_W  = 16,
    localparam int ID_W   = id_width(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*N_K-1:0] req_k,
    input  logic [N_REQ*N_B-1:0] req_m,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [N_B-1:0]       rsp_c,
`ifdef ENCRYPT_SCHED_STATS_EN
    output logic [CNT_W-1:0]     done_cnt,
`endif
    output logic                 busy
);

    localparam int CW = id_width(SETTLE);

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] id_q;
    logic [CW-1:0]   cnt;
    logic [N_K-1:0]  k_q;
    logic [N_B-1:0]  m_q;
    logic [N_B-1:0]  c_w;
    logic [ID_W:0]   pick;
    logic            gnt_any;
    logic [ID_W-1:0] gnt_idx;

    // Scan downward so the nearest valid requester after p overwrites farther ones.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v, input logic [ID_W-1:0] p);
        logic [ID_W:0] r;
        int            idx;
        r = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = (int'(p) + off) % N_REQ;
            if (v[idx]) r = {1'b1, idx[ID_W-1:0]};
        end
        return r;
    endfunction

    assign pick      = rr_pick(req_valid, ptr);
    assign gnt_any   = pick[ID_W];
    assign gnt_idx   = pick[ID_W-1:0];
    assign req_ready = (state == ST_IDLE && gnt_any) ? (N_REQ'(1) << gnt_idx) : '0;
    assign busy      = (state != ST_IDLE);

    encrypt_comb u_comb (
        .k (k_q),
        .m (m_q),
        .c (c_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= ID_W'(N_REQ - 1);
            id_q      <= '0;
            cnt       <= '0;
            k_q       <= '0;
            m_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
`ifdef ENCRYPT_SCHED_STATS_EN
            done_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        k_q   <= req_k[int'(gnt_idx)*N_K +: N_K];
                        m_q   <= req_m[int'(gnt_idx)*N_B +: N_B];
                        id_q  <= gnt_idx;
                        cnt   <= CW'(SETTLE - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        rsp_c     <= c_w;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= id_q;
                        state     <= ST_IDLE;
`ifdef ENCRYPT_SCHED_STATS_EN
                        done_cnt  <= done_cnt + CNT_W'(1);
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_sched.sv
// tb/tb_encrypt_sched.sv - scoreboard bench for encrypt_sched (N_REQ=2, SETTLE=2); set ENCRYPT_SCHED_STATS_EN for done_cnt checks
module tb_encrypt_sched;
    import encrypt_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_k;
    logic [31:0] req_m;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [15:0] rsp_c;
    logic        busy;
`ifdef ENCRYPT_SCHED_STATS_EN
    logic [15:0] done_cnt;
`endif

    encrypt_sched #(.N_REQ(2), .SETTLE(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_k     (req_k),
        .req_m     (req_m),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
`ifdef ENCRYPT_SCHED_STATS_EN
        .done_cnt  (done_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:0]  id;
        logic [15:0] c;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    int          ids[$];
    logic        m_busy = 1'b0;
    logic [0:0]  ptr_m = 1'b1;
    int          m_done = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rsp_cnt = 0;
    logic [15:0] v_k[2] = '{16'h1234, 16'hF00F};
    logic [15:0] v_m[2] = '{16'hABCD, 16'h0FF0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_enc(input logic [15:0] k, input logic [15:0] m);
        logic [15:0] x;
        x = k ^ m;
        return ((x << 3) | (x >> 13)) + ((k << 8) | (k >> 8));
    endfunction

    function automatic logic [1:0] model_ready(input logic [1:0] v, input logic [0:0] p);
        logic [0:0] first;
        first = p + 1'b1;
        if (v[first])  return 2'b01 << first;
        if (v[~first]) return 2'b01 << (~first);
        return 2'b00;
    endfunction

    // reference model and scoreboard, sampled on the falling edge
    initial forever begin
        logic [1:0] exp_rdy;
        logic [0:0] gi;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            sb.delete();
            m_busy = 1'b0;
            ptr_m  = 1'b1;
            m_done = 0;
        end else begin
            exp_rdy = m_busy ? 2'b00 : model_ready(req_valid, ptr_m);
            check_eq("req_ready", req_ready, exp_rdy);
            check_eq("busy", busy, m_busy);
            check_eq("rsp_valid", rsp_valid, m_busy && (cyc - acc_cyc >= 3));
`ifdef ENCRYPT_SCHED_STATS_EN
            check_eq("done_cnt", done_cnt, m_done);
`endif
            if (rsp_valid && sb.size() > 0) begin
                check_eq("rsp_id", rsp_id, sb[0].id);
                check_eq("rsp_c", rsp_c, sb[0].c);
                if (rsp_ready) begin
                    ids.push_back(int'(sb[0].id));
                    ptr_m = sb[0].id;
                    void'(sb.pop_front());
                    m_busy = 1'b0;
                    rsp_cnt++;
                    m_done++;
                end
            end
            if (|(req_valid & exp_rdy)) begin
                gi = exp_rdy[1];
                sb.push_back('{gi, ref_enc(req_k[gi*16 +: 16], req_m[gi*16 +: 16])});
                m_busy  = 1'b1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic set_vectors();
        req_k = {v_k[1], v_k[0]};
        req_m = {v_m[1], v_m[0]};
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // waits for the accept edge, then withdraws the request and scrambles the inputs
    task automatic accept_one();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) got = 1'b1;
        end
        check_eq("accept_timeout", got, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_k = $urandom;
        req_m = $urandom;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 60 && rsp_cnt < target; i++) @(posedge clk);
        check_eq("rsp_timeout", rsp_cnt >= target, 1'b1);
        #1;
    endtask

    task automatic wait_valid();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        check_eq("valid_timeout", got, 1'b1);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0; req_k = '0; req_m = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_req_ready", req_ready, 2'b00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rsp_c", rsp_c, 16'h0);
        check_eq("rst_rsp_id", rsp_id, 1'b0);
`ifdef ENCRYPT_SCHED_STATS_EN
        check_eq("rst_done_cnt", done_cnt, 16'h0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;

        // single request from requester 0
        set_vectors(); rsp_ready = 1'b1; req_valid = 2'b01;
        accept_one();
        wait_rsp(1);
        check_eq("single_id", ids[ids.size()-1], 0);

        // contention from a fresh pointer
        do_reset();
        base = ids.size();
        set_vectors(); req_valid = 2'b11;
        wait_rsp(rsp_cnt + 4);
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) check_eq($sformatf("rr_seq%0d", i), ids[base+i], i % 2);

        // backpressure in DONE
        repeat (4) @(posedge clk); #1;
        set_vectors(); rsp_ready = 1'b0; req_valid = 2'b01;
        accept_one();
        req_valid = 2'b11;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", rsp_valid, 1'b1);
            check_eq("bp_id", rsp_id, 1'b0);
            check_eq("bp_c", rsp_c, ref_enc(v_k[0], v_m[0]));
            check_eq("bp_ready", req_ready, 2'b00);
            check_eq("bp_busy", busy, 1'b1);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_rsp(rsp_cnt + 1);
        req_valid = 2'b00;
        repeat (6) @(posedge clk); #1;

        // reset during WAIT aborts requester 1
        set_vectors(); req_valid = 2'b10;
        accept_one();
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        base = rsp_cnt;
        repeat (6) @(posedge clk);
        check_eq("abort_no_rsp", rsp_cnt, base);
        #1 set_vectors(); req_valid = 2'b11;
        @(negedge clk);
        check_eq("abort_grant", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(base + 1);
        check_eq("abort_next_id", ids[ids.size()-1], 0);

`ifdef ENCRYPT_SCHED_STATS_EN
        do_reset();
        set_vectors(); rsp_ready = 1'b0; req_valid = 2'b01;
        accept_one();
        wait_valid();
        repeat (3) @(negedge clk);
        check_eq("stats_stalled", done_cnt, 16'd0);
        @(posedge clk); #1 rsp_ready = 1'b1; set_vectors(); req_valid = 2'b01;
        wait_rsp(rsp_cnt + 3);
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("stats_three", done_cnt, 16'd3);
`endif

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
